// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: instruction-field stream into the loader plus the
// instruction-memory write bus out of it. The loader uses the slave modport;
// the program source and the memory side use the master modport.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_fmt;
  logic [5:0]        in_opcode;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [15:0]       in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rs, in_rt, in_rd, in_imm,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rs, in_rt, in_rd, in_imm,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: accepts decoded instruction fields over valid/ready, packs
// them into 32-bit words and writes them sequentially into instruction memory
// starting at a latched base address. Stops after 'length' words or at the end
// of memory (sticky overflow, no wrap). All outputs are registered.
// Optional feature macro: LOADER_CHECKSUM_EN adds a 32-bit running checksum port.
module instr_mem_loader #(
  parameter int DEPTH  = 141,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  instr_mem_loader_if.slave bus
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // One extra bit so the end-of-memory compare cannot alias when DEPTH == 2**ADDR_W
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_X   = (ADDR_W+1)'(1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] len_reg, len_next;
  logic [ADDR_W-1:0] count_reg, count_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic              ovf_reg, ovf_next;
  logic              in_ready_reg, mem_we_reg, busy_reg, done_reg;
  logic [31:0]       packed_word;
  logic [ADDR_W:0]   addr_inc, count_inc;

  assign addr_inc  = {1'b0, addr_reg} + ONE_X;
  assign count_inc = {1'b0, count_reg} + ONE_X;

  // Field packing: I-type carries the full immediate, R-type keeps rd plus imm[10:0]
  always_comb begin
    if (bus.in_fmt) begin
      packed_word = {bus.in_opcode, bus.in_rs, bus.in_rt, bus.in_imm};
    end else begin
      packed_word = {bus.in_opcode, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm[10:0]};
    end
  end

  // Next-state and datapath update for the session FSM
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    len_next   = len_reg;
    count_next = count_reg;
    wdata_next = wdata_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          addr_next  = base_addr;
          len_next   = length;
          count_next = '0;
          ovf_next   = 1'b0;
          if (length == '0) begin
            state_next = DONE;
          end else if ({1'b0, base_addr} >= DEPTH_X) begin
            ovf_next   = 1'b1;
            state_next = DONE;
          end else begin
            state_next = ACCEPT;
          end
        end
      end
      ACCEPT: begin
        if (bus.in_valid && in_ready_reg) begin
          wdata_next = packed_word;
          state_next = WRITE;
        end
      end
      WRITE: begin
        count_next = count_inc[ADDR_W-1:0];
        // Length completion takes priority over hitting the end of memory
        if (count_inc == {1'b0, len_reg}) begin
          state_next = DONE;
        end else if (addr_inc == DEPTH_X) begin
          ovf_next   = 1'b1;
          state_next = DONE;
        end else begin
          addr_next  = addr_inc[ADDR_W-1:0];
          state_next = ACCEPT;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; outputs are decoded from the next state so they are flops
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      len_reg      <= '0;
      count_reg    <= '0;
      wdata_reg    <= '0;
      ovf_reg      <= 1'b0;
      in_ready_reg <= 1'b0;
      mem_we_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      len_reg      <= len_next;
      count_reg    <= count_next;
      wdata_reg    <= wdata_next;
      ovf_reg      <= ovf_next;
      in_ready_reg <= (state_next == ACCEPT);
      mem_we_reg   <= (state_next == WRITE);
      busy_reg     <= (state_next != IDLE);
      done_reg     <= (state_next == DONE);
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign overflow      = ovf_reg;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_reg;

  // Running sum of every word written in the current session
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      checksum_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      checksum_reg <= '0;
    end else if (mem_we_reg) begin
      checksum_reg <= checksum_reg + wdata_reg;
    end
  end

  assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed sessions against a queue-based write model.
// Build with LOADER_CHECKSUM_EN defined to also check the checksum port.
module tb_instr_mem_loader;
  localparam int DEPTH = 141;
  localparam int NW    = 6;

  typedef struct {
    bit fmt;
    int op;
    int rs;
    int rt;
    int rd;
    int imm;
  } word_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] length;
  logic       busy, done, overflow;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  instr_mem_loader_if #(.ADDR_W(8)) bus ();

  instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .overflow(overflow), .bus(bus)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  word_t       tab [0:NW-1];
  wr_t         exp_q[$];
  wr_t         wr_log[$];
  logic [31:0] exp_sum;
  int          cyc_cnt = 0;
  int          start_cyc;
  int          first_we_cyc;
  bit          prev_we = 0;
  bit          prev_done = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic fail_event(input string name, input longint act);
    total++;
    bad++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endtask

  // Instruction word from field values by plain arithmetic
  function automatic logic [31:0] model_word(input word_t w);
    longint v;
    v = longint'(w.op) * 67108864 + longint'(w.rs) * 2097152 + longint'(w.rt) * 65536;
    if (w.fmt) v = v + w.imm;
    else       v = v + longint'(w.rd) * 2048 + (w.imm % 2048);
    return v[31:0];
  endfunction

  task automatic drive_word(input int k);
    word_t w;
    w = tab[k % NW];
    bus.in_fmt    = w.fmt;
    bus.in_opcode = 6'(w.op);
    bus.in_rs     = 5'(w.rs);
    bus.in_rt     = 5'(w.rt);
    bus.in_rd     = 5'(w.rd);
    bus.in_imm    = 16'(w.imm);
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Compare process: every write must match the head of the expected queue
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.mem_we) begin
        if (prev_we) fail_event("we_back_to_back", bus.mem_addr);
        if (bus.in_ready) fail_event("ready_during_write", bus.mem_addr);
        if (exp_q.size() == 0) begin
          fail_event("unexpected_write", bus.mem_addr);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", bus.mem_addr, e.addr);
          check("wr_data", bus.mem_wdata, e.data);
        end
        wr_log.push_back('{bus.mem_addr, bus.mem_wdata});
        if (first_we_cyc < 0) first_we_cyc = cyc_cnt;
      end
      if (done && prev_done) fail_event("done_width", 1);
    end
    prev_we   = bus.mem_we;
    prev_done = done;
  end

  // One load session: builds the model, drives start/fields, checks session outcome
  task automatic run_session(input int base, input int len, input int first,
                             input int stall, input int abort_after);
    int n, cyc, idx, done_cyc, nwr;
    bit got_done, accepted, aborted, ovf_at_done, exp_ovf;
    n = 0;
    if (len > 0 && base < DEPTH) n = (len < DEPTH - base) ? len : DEPTH - base;
    exp_ovf = (len > 0) && (base >= DEPTH || len > DEPTH - base);
    exp_q.delete();
    wr_log.delete();
    exp_sum = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{8'(base + i), model_word(tab[(first + i) % NW])});
      exp_sum = exp_sum + model_word(tab[(first + i) % NW]);
    end
    $display("session base=%0d len=%0d stall=%0d abort=%0d expect_writes=%0d", base, len, stall, abort_after, n);
    @(negedge clk);
    start = 1; base_addr = 8'(base); length = 8'(len);
    start_cyc = cyc_cnt; first_we_cyc = -1;
    @(negedge clk);
    start = 0;
    idx = 0; cyc = 0; nwr = 0; got_done = 0; aborted = 0; done_cyc = -1; ovf_at_done = 0;
    while (!got_done && cyc < 300) begin
      start = (stall > 0 && cyc == stall / 2);
      if (start) begin base_addr = 8'd50; length = 8'd1; end
      if (stall > 0 && cyc == stall) begin
        check("stall_busy", busy, 1);
        check("stall_addr_kept", bus.mem_addr, base);
        check("stall_ready", bus.in_ready, 1);
        check("stall_no_write", nwr, 0);
      end
      if (bus.mem_we) nwr++;
      if (abort_after > 0 && nwr >= abort_after) begin
        reset_n = 0;
        aborted = 1;
        break;
      end
      if (cyc >= stall) begin drive_word(first + idx); bus.in_valid = 1; end
      else bus.in_valid = 0;
      if (done) begin got_done = 1; done_cyc = cyc; ovf_at_done = overflow; end
      accepted = bus.in_valid && bus.in_ready;
      @(negedge clk);
      cyc++;
      if (accepted) idx++;
    end
    start = 0;
    if (aborted) begin
      @(posedge clk);
      exp_q.delete();
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_ready", bus.in_ready, 0);
      check("abort_we", bus.mem_we, 0);
      check("abort_done", done, 0);
`ifdef LOADER_CHECKSUM_EN
      check("abort_checksum", checksum, 0);
`endif
      reset_n = 1;
      repeat (10) @(negedge clk);
      check("abort_stays_idle", busy, 0);
      bus.in_valid = 0;
      return;
    end
    bus.in_valid = 0;
    check("done_seen", got_done, 1);
    check("done_latency", done_cyc, 2 * n + stall);
    check("overflow", ovf_at_done, exp_ovf);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_pulse_end", done, 0);
    check("missing_writes", exp_q.size(), 0);
`ifdef LOADER_CHECKSUM_EN
    check("checksum", checksum, exp_sum);
`endif
  endtask

  initial begin
    tab[0] = '{1'b1, 'h08, 1,  2,  0,  'h0005};
    tab[1] = '{1'b0, 'h00, 1,  2,  3,  'h0020};
    tab[2] = '{1'b1, 'h23, 31, 17, 0,  'hFFFF};
    tab[3] = '{1'b0, 'h3F, 5,  6,  31, 'hFFFF};
    tab[4] = '{1'b1, 'h2B, 0,  31, 0,  'h8000};
    tab[5] = '{1'b0, 'h00, 31, 0,  0,  'h0805};

    // Reset with start and in_valid asserted must leave everything idle
    reset_n = 0; start = 1; base_addr = 8'd3; length = 8'd4;
    bus.in_valid = 1; drive_word(0);
    repeat (3) @(negedge clk);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("model_i_type", model_word(tab[0]), 32'h20220005);
    check("model_r_type", model_word(tab[1]), 32'h00221820);
    reset_n = 1; start = 0; bus.in_valid = 0;
    @(negedge clk);

    // Two-word session from address 0
    run_session(0, 2, 0, 0, 0);
    check("t2_first_we_latency", first_we_cyc - start_cyc, 2);
    check("t2_nwrites", wr_log.size(), 2);
    if (wr_log.size() >= 2) begin
      check("t2_word0", wr_log[0].data, 32'h20220005);
      check("t2_addr0", wr_log[0].addr, 0);
      check("t2_word1", wr_log[1].data, 32'h00221820);
      check("t2_addr1", wr_log[1].addr, 1);
    end
`ifdef LOADER_CHECKSUM_EN
    check("t2_checksum_literal", checksum, 32'h20441825);
`endif

    // Runs off the end of memory: writes at 139 and 140 only
    run_session(139, 5, 2, 0, 0);
    repeat (3) @(negedge clk);
    check("t3_overflow_sticky", overflow, 1);

    // Zero-length session clears overflow and writes nothing
    run_session(0, 0, 0, 0, 0);

    // Stalled source with a stray start pulse mid-session
    run_session(10, 3, 3, 10, 0);

    // Reset after the first write of a four-word session
    run_session(20, 4, 1, 0, 1);

    // Boundaries: last address exactly, base beyond memory, longer run
    run_session(140, 1, 4, 0, 0);
    run_session(141, 3, 0, 0, 0);
    run_session(100, 6, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
